// File: rtl/rst_req_ctrl_if.sv
// rst_req_ctrl_if: request / reset-manager signal bundle for rst_req_ctrl.
// The slave modport is the controller; the master modport is the side that
// raises requests and models the reset manager.
interface rst_req_ctrl_if;
    logic       dbg_req_i;
    logic       sw_req_i;
    logic       wdog_req_i;
    logic       sys_rst_ni_i;
    logic       ndmreset_o;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;
    logic [2:0] cause_o;

    modport slave (
        input  dbg_req_i, sw_req_i, wdog_req_i, sys_rst_ni_i,
        output ndmreset_o, busy_o, done_o, timeout_o, cause_o
    );

    modport master (
        output dbg_req_i, sw_req_i, wdog_req_i, sys_rst_ni_i,
        input  ndmreset_o, busy_o, done_o, timeout_o, cause_o
    );
endinterface

// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: sequences a non-debug-module reset request towards the reset
// manager. A request pulses ndmreset_o for a minimum time, waits for the
// system reset to assert and release, then signals completion. Requests that
// arrive mid-sequence are queued as a single pending re-run.
// Optional feature: define RST_REQ_CAUSE_EN to latch the request cause on
// cause_o ({wdog,dbg,sw}); otherwise cause_o is tied to 3'b000.
module rst_req_ctrl #(
    parameter int unsigned MIN_PULSE = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rst_req_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ASSERT    = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4
    } state_e;

    // The pulse counter counts ndmreset_o-high cycles including the current
    // one. WAIT_LOW always adds at least one more high cycle, so ASSERT may
    // leave once the count reaches MIN_PULSE-1 and the total high time is
    // still at least MIN_PULSE.
    localparam logic [7:0]  PULSE_LAST = 8'(MIN_PULSE - 1);
    localparam logic [7:0]  PULSE_MAX  = 8'hff;
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  pulse_cnt_q;
    logic [15:0] wait_cnt_q;
    logic        pend_q;

    logic        ndmreset_q, busy_q, done_q, timeout_q;
    logic        ndmreset_d, busy_d, done_d, timeout_d;

    logic        req_any;
    logic        pend_hit;
    logic        pulse_met;
    logic        wait_exp;
    logic        timeout_set;
    logic        start_idle;
    logic        start_done;

    assign req_any   = bus.wdog_req_i | bus.dbg_req_i | bus.sw_req_i;
    assign pulse_met = (pulse_cnt_q >= PULSE_LAST);
    assign wait_exp  = (wait_cnt_q == WAIT_LAST);

    // Mid-sequence only the pulse requests queue a re-run; in DONE a held
    // debug request also counts, as does any request arriving in DONE itself.
    assign pend_hit = (state_q == DONE) ? req_any :
                      (state_q != IDLE) && (bus.sw_req_i | bus.wdog_req_i);

    // A wait phase expires only if the awaited edge has not been seen.
    assign timeout_set = wait_exp &&
                         (((state_q == WAIT_LOW)  &&  bus.sys_rst_ni_i) ||
                          ((state_q == WAIT_HIGH) && !bus.sys_rst_ni_i));

    assign start_idle = (state_q == IDLE) && (state_d == ASSERT);
    assign start_done = (state_q == DONE) && (state_d == ASSERT);

    // State and registered outputs; rst_i aborts any sequence on the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ndmreset_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ndmreset_q <= ndmreset_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) state_d = ASSERT;
            end
            ASSERT: begin
                if (pulse_met && !bus.dbg_req_i) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!bus.sys_rst_ni_i) state_d = WAIT_HIGH;
                else if (wait_exp)     state_d = DONE;
            end
            WAIT_HIGH: begin
                if (bus.sys_rst_ni_i || wait_exp) state_d = DONE;
            end
            DONE: begin
                state_d = (pend_q || pend_hit) ? ASSERT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs follow the next state so they change on the same edge as it.
    always_comb begin
        ndmreset_d = (state_d == ASSERT) || (state_d == WAIT_LOW);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        timeout_d  = timeout_q;
        if (start_idle)       timeout_d = 1'b0;
        else if (timeout_set) timeout_d = 1'b1;
    end

    // Pulse counter saturates; wait counter restarts on each wait phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pulse_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (start_idle || start_done)
                pulse_cnt_q <= 8'd1;
            else if ((state_q == ASSERT) && (pulse_cnt_q != PULSE_MAX))
                pulse_cnt_q <= pulse_cnt_q + 8'd1;

            if ((state_d != state_q) &&
                ((state_d == WAIT_LOW) || (state_d == WAIT_HIGH)))
                wait_cnt_q <= '0;
            else if ((state_q == WAIT_LOW) || (state_q == WAIT_HIGH))
                wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Single pending bit; consumed (or dropped) when DONE is left.
    always_ff @(posedge clk_i) begin
        if (rst_i)                pend_q <= 1'b0;
        else if (state_q == DONE) pend_q <= 1'b0;
        else if (pend_hit)        pend_q <= 1'b1;
    end

`ifdef RST_REQ_CAUSE_EN
    logic [2:0] req_vec;
    logic [2:0] cause_q;
    logic [2:0] pend_cause_q;

    assign req_vec = {bus.wdog_req_i, bus.dbg_req_i, bus.sw_req_i};

    // Cause capture on sequence start and accumulation of pending causes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_q      <= '0;
            pend_cause_q <= '0;
        end else begin
            if (start_idle)      cause_q <= req_vec;
            else if (start_done) cause_q <= pend_cause_q | req_vec;

            if (state_q == DONE)
                pend_cause_q <= '0;
            else if (pend_hit)
                pend_cause_q <= pend_cause_q | {bus.wdog_req_i, 1'b0, bus.sw_req_i};
        end
    end

    assign bus.cause_o = cause_q;
`else
    assign bus.cause_o = 3'b000;
`endif

    assign bus.ndmreset_o = ndmreset_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb_rst_req_ctrl: directed sequences with a scoreboard. Stimulus pushes the
// expected completion record; a monitor pops one on every done_o pulse.
`timescale 1ns/1ps
module tb_rst_req_ctrl;

`ifdef RST_REQ_CAUSE_EN
    localparam bit CAUSE_EN = 1'b1;
`else
    localparam bit CAUSE_EN = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic [2:0]  cause;
        logic        to;
        int unsigned hlen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        model_en = 1'b1;
    logic        d1 = 1'b0, d2 = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    exp_t        q[$];

    rst_req_ctrl_if bus();

    rst_req_ctrl #(.MIN_PULSE(16), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reset manager: sys_rst_ni follows ndmreset_o inverted, 2 cycles late.
    always @(posedge clk) begin
        d1 <= bus.ndmreset_o;
        d2 <= d1;
    end
    assign bus.sys_rst_ni_i = model_en ? ~d2 : 1'b1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int unsigned n);
        if (cyc > n) check("schedule", cyc, n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic expect_seq(input int unsigned c, input logic [2:0] cause,
                              input logic to, input int unsigned hlen);
        exp_t e;
        e.cyc   = c;
        e.cause = CAUSE_EN ? cause : 3'b000;
        e.to    = to;
        e.hlen  = hlen;
        q.push_back(e);
    endtask

    task automatic pulse_sw(input int unsigned n);
        at_cycle(n);
        bus.sw_req_i = 1'b1;
        at_cycle(n + 1);
        bus.sw_req_i = 1'b0;
    endtask

    // Monitor: measures ndmreset_o high time and checks each completion.
    initial begin : mon
        int unsigned hcnt;
        exp_t e;
        hcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.ndmreset_o) hcnt++;
            if (!bus.busy_o) hcnt = 0;
            if (bus.done_o) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done @cycle %0d: done_o=1, expected no completion", cyc);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("cause", 32'(bus.cause_o), 32'(e.cause));
                    check("timeout", 32'(bus.timeout_o), 32'(e.to));
                    check("ndm_high_len", hcnt, e.hlen);
                    check("ndm_at_done", 32'(bus.ndmreset_o), 0);
                    check("busy_at_done", 32'(bus.busy_o), 1);
                end
                hcnt = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bus.dbg_req_i  = 1'b0;
        bus.sw_req_i   = 1'b0;
        bus.wdog_req_i = 1'b0;

        // Reset state
        at_cycle(3);
        check("rst_ndm", 32'(bus.ndmreset_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_timeout", 32'(bus.timeout_o), 0);
        check("rst_cause", 32'(bus.cause_o), 0);
        rst = 1'b0;

        // sw request: high 11..26, done at 30
        expect_seq(30, 3'b001, 1'b0, 16);
        pulse_sw(10);
        at_cycle(20);
        check("mid_ndm", 32'(bus.ndmreset_o), 1);
        check("mid_busy", 32'(bus.busy_o), 1);

        // dbg held 40 cycles: ASSERT until dbg falls, high 51..91
        expect_seq(95, 3'b010, 1'b0, 41);
        at_cycle(50);
        bus.dbg_req_i = 1'b1;
        at_cycle(90);
        bus.dbg_req_i = 1'b0;
        check("dbg_hold_ndm", 32'(bus.ndmreset_o), 1);

        // sys_rst_ni stuck high: WAIT_LOW times out after 8 cycles
        at_cycle(100);
        model_en = 1'b0;
        expect_seq(134, 3'b001, 1'b1, 23);
        pulse_sw(110);
        at_cycle(140);
        check("timeout_sticky", 32'(bus.timeout_o), 1);
        check("timeout_idle_ndm", 32'(bus.ndmreset_o), 0);
        model_en = 1'b1;

        // wdog during WAIT_HIGH re-runs immediately after done
        expect_seq(170, 3'b001, 1'b0, 16);
        expect_seq(190, 3'b100, 1'b0, 16);
        pulse_sw(150);
        at_cycle(168);
        bus.wdog_req_i = 1'b1;
        at_cycle(169);
        bus.wdog_req_i = 1'b0;

        // request in the DONE cycle itself is pending
        expect_seq(230, 3'b001, 1'b0, 16);
        expect_seq(250, 3'b001, 1'b0, 16);
        pulse_sw(210);
        pulse_sw(230);

        // simultaneous sw + wdog in IDLE
        expect_seq(290, 3'b101, 1'b0, 16);
        at_cycle(270);
        bus.sw_req_i   = 1'b1;
        bus.wdog_req_i = 1'b1;
        at_cycle(271);
        bus.sw_req_i   = 1'b0;
        bus.wdog_req_i = 1'b0;

        // rst in the 5th ASSERT cycle aborts and drops a pending wdog
        pulse_sw(310);
        at_cycle(313);
        bus.wdog_req_i = 1'b1;
        at_cycle(314);
        bus.wdog_req_i = 1'b0;
        at_cycle(315);
        rst = 1'b1;
        at_cycle(316);
        rst = 1'b0;
        check("abort_ndm", 32'(bus.ndmreset_o), 0);
        check("abort_busy", 32'(bus.busy_o), 0);
        check("abort_cause", 32'(bus.cause_o), 0);
        check("abort_done", 32'(bus.done_o), 0);
        at_cycle(330);
        check("abort_no_rerun", 32'(bus.busy_o), 0);

        // dbg held through reset starts on the first free cycle
        at_cycle(340);
        rst = 1'b1;
        bus.dbg_req_i = 1'b1;
        expect_seq(363, 3'b010, 1'b0, 16);
        at_cycle(343);
        rst = 1'b0;
        check("post_rst_idle", 32'(bus.busy_o), 0);
        at_cycle(344);
        check("post_rst_ndm", 32'(bus.ndmreset_o), 1);
        at_cycle(345);
        bus.dbg_req_i = 1'b0;

        at_cycle(400);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_req_ctrl.md
RST_REQ_CTRL -- requirements
Module: rst_req_ctrl

Interface
REQ-001 SHALL: parameter MIN_PULSE, default 16, minimum ndmreset_o high time in cycles (range 1..255).
REQ-002 SHALL: parameter TIMEOUT, default 1024, maximum cycles spent waiting on sys_rst_ni_i per phase (range 2..65535).
REQ-003 SHALL: clk_i  input  1  system clock; the block uses one clock.
REQ-004 SHALL: rst_i  input  1  reset, synchronous to clk_i and active-high.
REQ-005 SHALL: dbg_req_i  input  1  debug non-debug-module reset request, level.
REQ-006 SHALL: sw_req_i  input  1  software reset request, single-cycle pulse.
REQ-007 SHALL: wdog_req_i  input  1  watchdog reset request, single-cycle pulse.
REQ-008 SHALL: sys_rst_ni_i  input  1  system reset feedback from the reset manager, active-low.
REQ-009 SHALL: ndmreset_o  output  1  reset request to the reset manager, active-high.
REQ-010 SHALL: busy_o  output  1  high in every state except IDLE.
REQ-011 SHALL: done_o  output  1  one-cycle pulse on sequence completion.
REQ-012 SHALL: timeout_o  output  1  sticky flag, set when any wait phase expires.
REQ-013 SHALL: cause_o  output  3  latched request cause, {wdog,dbg,sw}.

Function
REQ-014 SHALL: FSM states are IDLE, ASSERT, WAIT_LOW, WAIT_HIGH and DONE; all outputs are registered.
REQ-015 SHALL: in IDLE, any request (wdog_req_i | dbg_req_i | sw_req_i) moves to ASSERT on the next edge, and ndmreset_o rises in that same edge.
REQ-016 SHALL: on entry to ASSERT, cause_o captures all request bits present that cycle, one-hot or multi-hot.
REQ-017 SHALL: ASSERT holds ndmreset_o high for at least MIN_PULSE cycles, counted by an 8-bit counter that saturates.
REQ-018 SHALL: ASSERT extends beyond MIN_PULSE while dbg_req_i stays high; the block moves to WAIT_LOW on the first cycle with count ≥ MIN_PULSE and dbg_req_i low.
REQ-019 SHALL: WAIT_LOW keeps ndmreset_o high until sys_rst_ni_i is sampled low, then moves to WAIT_HIGH with ndmreset_o low on that edge; if sys_rst_ni_i is already low, this takes exactly 1 cycle.
REQ-020 SHALL: WAIT_HIGH keeps ndmreset_o low until sys_rst_ni_i is sampled high, then moves to DONE.
REQ-021 SHALL: DONE lasts one cycle, drives done_o=1, and then goes to IDLE, or to ASSERT if a request is pending.
REQ-022 SHALL: a 16-bit wait counter clears on entry to WAIT_LOW and on entry to WAIT_HIGH; when it reaches TIMEOUT-1, the block sets timeout_o and moves to DONE with ndmreset_o low.
REQ-023 SHALL: sw_req_i or wdog_req_i pulses arriving in any non-IDLE state set a single pending bit and OR into a pending-cause register; dbg_req_i high at DONE also counts as pending.
REQ-024 SHALL: on the move from DONE to ASSERT, cause_o loads the pending-cause register, and both the pending bit and the pending-cause register clear.
REQ-025 SHALL: a request arriving in the DONE cycle itself is treated as pending.
REQ-026 SHALL: timeout_o clears only on rst_i or when a new sequence is entered from IDLE.

Reset
REQ-027 SHALL: while rst_i is high at a clk_i edge, state becomes IDLE, all counters become 0, the pending bit and pending-cause register clear, and ndmreset_o=0, busy_o=0, done_o=0, timeout_o=0, cause_o=3'b000.
REQ-028 SHALL: rst_i asserted mid-sequence aborts the sequence, drops ndmreset_o on the same edge, and loses any pending request.
REQ-029 SHALL: on the first cycle after rst_i deasserts, a request held high (dbg_req_i) starts a sequence normally.

Configuration
REQ-030 SHALL: when macro RST_REQ_CAUSE_EN is defined, cause_o and the pending-cause register behave as specified in REQ-016, REQ-023 and REQ-024.
REQ-031 SHALL: when RST_REQ_CAUSE_EN is undefined, cause_o is constant 3'b000, no cause storage exists, and all other behaviour is unchanged.

Verification
REQ-032 SHALL: sw_req_i pulse at cycle 10, with a reset-manager model that drops sys_rst_ni_i 2 cycles after ndmreset_o rises and raises it 2 cycles after ndmreset_o falls -> ndmreset_o high cycles 11..26 (16 cycles), done_o pulse 1 cycle, cause_o=3'b001.
REQ-033 SHALL: dbg_req_i held high for 40 cycles -> ndmreset_o high at least 40 cycles, WAIT_LOW entered only after dbg_req_i falls, cause_o=3'b010.
REQ-034 SHALL: sys_rst_ni_i tied high, TIMEOUT=8 -> WAIT_LOW exits after 8 cycles, timeout_o=1, done_o pulses, ndmreset_o=0.
REQ-035 SHALL: wdog_req_i pulse during WAIT_HIGH of a sw sequence -> after done_o, ASSERT is re-entered immediately and cause_o=3'b100.
REQ-036 SHALL: rst_i pulsed in the 5th ASSERT cycle -> next edge gives ndmreset_o=0, busy_o=0, cause_o=0, and no done_o.
REQ-037 SHALL: sw_req_i and wdog_req_i in the same IDLE cycle with RST_REQ_CAUSE_EN defined -> cause_o=3'b101; with the macro undefined -> cause_o=3'b000.
